batch_correlator: RTL and testbench
===================================

// Module: batch_correlator
// PURPOSE
//  Downstream consumer of the shifted-batch input buffer. Receives RUNS batches of BATCH_SIZE
//  samples framed by sop/eop/valid. Multiplies each sample by the coefficient at its position
//  in the batch and accumulates. Emits one correlation result per batch, so RUNS lags per run.
//  Coefficients sit in a local RAM written through a separate port.
// PARAMETERS
//  BATCH_SIZE  64  samples per batch; coefficient RAM depth
//  RUNS        16  batches (results) per run
//  DATA_WIDTH  16  sample width, Q<DATA_WIDTH>.0
//  COEF_WIDTH  16  coefficient width, Q<COEF_WIDTH>.0
//  ACC_WIDTH   DATA_WIDTH+COEF_WIDTH+$clog2(BATCH_SIZE)  result width (derived localparam)
// PORTS
//  sink_clk     in   1                    clock; sink and source side share this domain
//  reset        in   1                    reset, synchronous, active-high
//  coef_wr      in   1                    coefficient write strobe
//  coef_addr    in   $clog2(BATCH_SIZE)   coefficient write address
//  coef_data    in   COEF_WIDTH           coefficient write data, Q<COEF_WIDTH>.0
//  sink_sop     in   1                    first sample of a batch
//  sink_eop     in   1                    last sample of a batch
//  sink_valid   in   1                    sample qualifier; sop, eop and data are ignored while low
//  sink_data    in   DATA_WIDTH           sample, Q<DATA_WIDTH>.0
//  source_sop   out  1                    result of first batch of a run
//  source_eop   out  1                    result of last batch of a run
//  source_valid out  1                    result strobe, one cycle per batch
//  source_data  out  ACC_WIDTH            correlation result, Q<ACC_WIDTH>.0
//  error        out  1                    sticky framing error; cleared only by reset
// BEHAVIOUR
//  Reset values:
//   - source_valid, source_sop, source_eop, error, source_data = 0.
//   - FSM = IDLE; sample index = 0; result counter = 0; pipeline valid flags = 0.
//   - Coefficient RAM is NOT cleared.
//  Reset asserted mid-batch: partial batch is discarded; no result is emitted.
//  FSM:
//   - IDLE: a valid&sop beat moves to BATCH with idx=0. Valid beats without sop set error.
//   - BATCH:
//       * Each valid beat uses idx as the coefficient address, then idx+1.
//       * valid&eop with idx==BATCH_SIZE-1 closes the batch and returns to IDLE.
//       * valid&eop with any other idx sets error; batch is dropped; return to IDLE.
//       * valid&sop with idx!=0 sets error; batch restarts at idx=0.
//       * idx reaching BATCH_SIZE-1 without eop, then a further non-sop beat: error; go to DISCARD.
//   - DISCARD: drops every beat until valid&sop, which restarts as in IDLE.
//   - Single-beat batch (sop&eop together) is legal only when BATCH_SIZE==1.
//  Pipeline (valid-flagged, no backpressure; sink_valid gaps of any length are allowed):
//   - S1: register sample, sop/eop/keep flags; coef RAM read (registered).
//   - S2: signed product, DATA_WIDTH+COEF_WIDTH bits.
//   - S3: sign-extend product to ACC_WIDTH. acc = sop ? prod : acc+prod.
//  Latency: eop beat in cycle t gives source_valid=1 in cycle t+3 for exactly one cycle.
//   - source_data holds its value until the next result.
//   - source_sop and source_eop are valid only while source_valid=1.
//  Arithmetic: full precision; ACC_WIDTH sized so no overflow is possible; no saturation or rounding.
//  Result counter: 0..RUNS-1.
//   - source_sop = (cnt==0); source_eop = (cnt==RUNS-1); then wraps to 0.
//   - Dropped batches do not advance it.
//  Coefficient write:
//   - Allowed at any time.
//   - Same-cycle write and read of one address returns the old value.
//   - New value is used from the next read onward.
// STRUCTURE
//  pr3_pkg:
//   - typedef enum {IDLE, BATCH, DISCARD} corr_state_t.
//   - function acc_width(dw, cw, n).
//  Sub-module coef_ram: 1 write port, 1 registered read port, depth BATCH_SIZE, width COEF_WIDTH.
//  Top level holds the FSM, idx and result counters, the 3-stage pipeline and output registers.
// TESTING  (BATCH_SIZE=4, RUNS=3, DATA_WIDTH=8, COEF_WIDTH=8 unless stated)
//  1. Nominal run. Coef {1,2,3,4}; upstream buffer loaded with 1..6.
//     -> results 30, 40, 50; source_sop on result 1; source_eop on result 3; each 3 cycles after its eop.
//  2. Extremes. Coef all -128; data all -128.
//     -> results 65536 (18-bit signed); no wrap.
//  3. Early eop. Eop on 3rd beat.
//     -> no result; error=1; next well-framed batch result is correct; result counter unchanged.
//  4. Gaps. sink_valid toggling 1-0-0-1 through a batch.
//     -> results identical to test 1.
//  5. Reset mid-batch. Reset after beat 2.
//     -> all outputs 0 next cycle; following run gives 30, 40, 50 with correct sop/eop.
//  6. Coefficient update. Write coef[0]=10 between batch 1 and batch 2.
//     -> results 30, 58, 77.

Source files
------------

// File: rtl/batch_correlator_pkg.sv
// Shared types and sizing helpers for the batch correlator.
package batch_correlator_pkg;

  // Framing FSM: IDLE waits for sop, BATCH accumulates, DISCARD drops until sop.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BATCH   = 2'd1,
    DISCARD = 2'd2
  } corr_state_t;

  // Result width that holds a full-precision sum of n products without overflow.
  function automatic int acc_width(input int dw, input int cw, input int n);
    return dw + cw + $clog2(n);
  endfunction

  // Address width that never collapses to zero bits for a depth of one.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/batch_correlator_coef_ram.sv
// Coefficient store: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module batch_correlator_coef_ram
  import batch_correlator_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 16,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is deliberately not reset; read data is registered every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/batch_correlator.sv
// Batch correlator: multiplies each sample by the coefficient at its batch
// position and emits one accumulated result per well-framed batch.
//
// Stream semantics (no backpressure): sink_sop/sink_eop/sink_data are only
// meaningful in a cycle where sink_valid=1; gaps of any length are allowed.
// source_valid pulses for one cycle per result; source_sop/source_eop are
// only meaningful while source_valid=1; source_data holds until the next result.
module batch_correlator
  import batch_correlator_pkg::*;
#(
  parameter  int BATCH_SIZE = 64,
  parameter  int RUNS       = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int COEF_WIDTH = 16,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, BATCH_SIZE),
  localparam int AW         = addr_width(BATCH_SIZE)
) (
  input  logic                  sink_clk,
  input  logic                  reset,
  input  logic                  coef_wr,
  input  logic [AW-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0] coef_data,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic                  sink_valid,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic                  source_valid,
  output logic [ACC_WIDTH-1:0]  source_data,
  output logic                  error
);

  // idx counts one past the last position so "all positions used, no eop" is visible.
  localparam int IW = AW + 1;
  localparam int NW = addr_width(RUNS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(BATCH_SIZE - 1);
  localparam logic [IW-1:0] FULL_IDX = IW'(BATCH_SIZE);
  localparam logic [NW-1:0] LAST_CNT = NW'(RUNS - 1);

  corr_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          error_q, error_d;

  // Per-beat decode
  logic          beat_keep, beat_first, beat_last;
  logic [AW-1:0] beat_pos;

  // Pipeline stages
  logic                         s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0]        s1_data_q, s1_data_d;
  logic [COEF_WIDTH-1:0]        coef_rd;
  logic                         s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]  prod_ext, acc_sum, acc_q, acc_d;
  logic                         emit;

  // Output stage
  logic                  source_valid_q, source_valid_d;
  logic                  source_sop_q, source_sop_d;
  logic                  source_eop_q, source_eop_d;
  logic [ACC_WIDTH-1:0]  source_data_q, source_data_d;
  logic [NW-1:0]         cnt_q, cnt_d;

  // Framing FSM: decides which beats contribute, which start and which close a batch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    error_d    = error_q;
    beat_keep  = 1'b0;
    beat_first = 1'b0;
    beat_last  = 1'b0;
    beat_pos   = '0;
    if (sink_valid) begin
      if (sink_sop) begin
        // A sop always (re)starts at position 0; mid-batch it also flags an error.
        if (state_q == BATCH) error_d = 1'b1;
        beat_keep  = 1'b1;
        beat_first = 1'b1;
        if (sink_eop) begin
          state_d = IDLE;
          idx_d   = '0;
          if (BATCH_SIZE == 1) begin
            beat_last = 1'b1;
          end else begin
            error_d   = 1'b1;
            beat_keep = 1'b0;
          end
        end else begin
          state_d = BATCH;
          idx_d   = IW'(1);
        end
      end else begin
        case (state_q)
          IDLE: error_d = 1'b1;
          BATCH: begin
            if (idx_q == FULL_IDX) begin
              // Batch overran without eop: abandon it until the next sop.
              error_d = 1'b1;
              state_d = DISCARD;
              idx_d   = '0;
            end else begin
              beat_keep = 1'b1;
              beat_pos  = idx_q[AW-1:0];
              if (sink_eop) begin
                state_d = IDLE;
                idx_d   = '0;
                if (idx_q == LAST_IDX) begin
                  beat_last = 1'b1;
                end else begin
                  error_d   = 1'b1;
                  beat_keep = 1'b0;
                end
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end
          end
          DISCARD: ;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  batch_correlator_coef_ram #(
    .DEPTH (BATCH_SIZE),
    .WIDTH (COEF_WIDTH)
  ) u_coef_ram (
    .clk     (sink_clk),
    .wr_en   (coef_wr),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_addr (beat_pos),
    .rd_data (coef_rd)
  );

  // Datapath: S1 capture, S2 multiply, S3 accumulate and present the result.
  always_comb begin
    s1_valid_d = beat_keep;
    s1_first_d = beat_first;
    s1_last_d  = beat_last;
    s1_data_d  = sink_data;
    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_last_d  = s1_last_q;
    prod_d     = PW'($signed(s1_data_q)) * PW'($signed(coef_rd));
    prod_ext   = ACC_WIDTH'(prod_q);
    acc_sum    = s2_first_q ? prod_ext : acc_q + prod_ext;
    acc_d      = s2_valid_q ? acc_sum : acc_q;
    emit           = s2_valid_q & s2_last_q;
    source_valid_d = emit;
    source_sop_d   = emit & (cnt_q == '0);
    source_eop_d   = emit & (cnt_q == LAST_CNT);
    source_data_d  = emit ? acc_sum : source_data_q;
    cnt_d          = cnt_q;
    if (emit) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + NW'(1);
  end

  // All state registers; synchronous active-high reset drops any partial batch.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      error_q        <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_data_q      <= '0;
      s2_valid_q     <= 1'b0;
      s2_first_q     <= 1'b0;
      s2_last_q      <= 1'b0;
      prod_q         <= '0;
      acc_q          <= '0;
      source_valid_q <= 1'b0;
      source_sop_q   <= 1'b0;
      source_eop_q   <= 1'b0;
      source_data_q  <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      error_q        <= error_d;
      s1_valid_q     <= s1_valid_d;
      s1_first_q     <= s1_first_d;
      s1_last_q      <= s1_last_d;
      s1_data_q      <= s1_data_d;
      s2_valid_q     <= s2_valid_d;
      s2_first_q     <= s2_first_d;
      s2_last_q      <= s2_last_d;
      prod_q         <= prod_d;
      acc_q          <= acc_d;
      source_valid_q <= source_valid_d;
      source_sop_q   <= source_sop_d;
      source_eop_q   <= source_eop_d;
      source_data_q  <= source_data_d;
      cnt_q          <= cnt_d;
    end
  end

  assign source_valid = source_valid_q;
  assign source_sop   = source_sop_q;
  assign source_eop   = source_eop_q;
  assign source_data  = source_data_q;
  assign error        = error_q;

endmodule

// File: tb/tb_batch_correlator.sv
// Bench for batch_correlator: directed scenarios plus randomized batches,
// expected results queued at issue time and matched by an output monitor.
module tb_batch_correlator;

  localparam int BS   = 4;
  localparam int RUNS = 3;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int ACC  = DW + CW + $clog2(BS);
  localparam int AW   = $clog2(BS);
  localparam int EW   = 32 + 2 + ACC;

  logic            sink_clk = 1'b0;
  logic            reset = 1'b1;
  logic            coef_wr = 1'b0;
  logic [AW-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_data = '0;
  logic            sink_sop = 1'b0;
  logic            sink_eop = 1'b0;
  logic            sink_valid = 1'b0;
  logic [DW-1:0]   sink_data = '0;
  logic            source_sop, source_eop, source_valid, error;
  logic [ACC-1:0]  source_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0]  exp_q[$];          // {expected cycle, sop, eop, data}
  int             coef_model[BS];    // coefficient contents as the bench believes them
  int             batch_d[BS];       // samples of the next batch to send
  int             res_cnt = 0;       // position of the next result within its run
  logic [ACC-1:0] last_data = '0;

  batch_correlator #(
    .BATCH_SIZE (BS),
    .RUNS       (RUNS),
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW)
  ) dut (
    .sink_clk     (sink_clk),
    .reset        (reset),
    .coef_wr      (coef_wr),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_valid   (sink_valid),
    .sink_data    (sink_data),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_valid (source_valid),
    .source_data  (source_data),
    .error        (error)
  );

  // ---------------- clock / cycle count ----------------
  always #5 sink_clk = ~sink_clk;
  always @(posedge sink_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sink_clk);
    #1;
  endtask

  // Idle cycle with random junk on the qualified-by-valid inputs.
  task automatic gap();
    sink_valid = 1'b0;
    sink_sop   = 1'($urandom);
    sink_eop   = 1'($urandom);
    sink_data  = DW'($urandom);
    tick();
  endtask

  task automatic gaps(input int mode);
    int n;
    n = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(0, 3);
    for (int g = 0; g < n; g++) gap();
  endtask

  task automatic beat(input logic sop, input logic eop, input int d);
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_data  = DW'(d);
    tick();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic write_coef(input int a, input int v);
    sink_valid = 1'b0;
    coef_wr    = 1'b1;
    coef_addr  = AW'(a);
    coef_data  = CW'(v);
    tick();
    coef_wr = 1'b0;
    coef_model[a] = v;
  endtask

  // Well-framed batch from batch_d; optionally writes coef[wr_at] during that beat.
  task automatic send_good(input int gap_mode, input int wr_at, input int wr_val);
    int sum;
    int ec;
    sum = 0;
    ec  = 0;
    for (int i = 0; i < BS; i++) begin
      sum += batch_d[i] * coef_model[i];
      if (i == wr_at) begin
        coef_wr   = 1'b1;
        coef_addr = AW'(i);
        coef_data = CW'(wr_val);
      end
      if (i == BS - 1) ec = cyc + 3;
      beat(i == 0, i == BS - 1, batch_d[i]);
      if (i == wr_at) begin
        coef_wr = 1'b0;
        coef_model[i] = wr_val;
      end
      if (i != BS - 1) gaps(gap_mode);
    end
    exp_q.push_back({32'(ec), res_cnt == 0, res_cnt == RUNS - 1, ACC'(sum)});
    res_cnt = (res_cnt + 1) % RUNS;
  endtask

  // Batch closed early by eop on beat n (n < BS): dropped.
  task automatic send_short(input int n);
    for (int i = 0; i < n; i++) begin
      beat(i == 0, i == n - 1, $urandom_range(0, 255));
      gaps(2);
    end
  endtask

  // Batch that runs past its last position without eop, then stray beats: dropped.
  task automatic send_long();
    for (int i = 0; i < BS + 3; i++) begin
      beat(i == 0, 1'b0, $urandom_range(0, 255));
      gaps(2);
    end
  endtask

  task automatic flush();
    sink_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic set_window(input int start);
    for (int i = 0; i < BS; i++) batch_d[i] = start + i;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge sink_clk);
      if (reset) begin
        last_data = '0;
      end else if (source_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got data %0h, none pending", source_data);
        end else begin
          e = exp_q.pop_front();
          check("result_data", source_data, e[ACC-1:0]);
          check("result_sop", source_sop, e[ACC+1]);
          check("result_eop", source_eop, e[ACC]);
          check("result_cycle", cyc, e[EW-1 -: 32]);
        end
        last_data = source_data;
      end else begin
        check("hold_data", source_data, last_data);
        check("idle_flags", {source_sop, source_eop}, 2'b00);
        while (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_result: got nothing by cycle %0d, expected data %0h at cycle %0d",
                   cyc, e[ACC-1:0], e[EW-1 -: 32]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int mode;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_valid", source_valid, 0);
    check("reset_sop", source_sop, 0);
    check("reset_eop", source_eop, 0);
    check("reset_data", source_data, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    tick();

    // Nominal run over a shifting window of 1..6
    for (int i = 0; i < BS; i++) write_coef(i, i + 1);
    for (int k = 0; k < 3; k++) begin
      set_window(k + 1);
      send_good(0, -1, 0);
    end
    flush();

    // Same run with valid toggling 1-0-0-1
    for (int k = 0; k < 3; k++) begin
      set_window(k + 1);
      send_good(1, -1, 0);
    end
    flush();

    // Coefficient update between batches
    set_window(1);
    send_good(0, -1, 0);
    write_coef(0, 10);
    for (int k = 1; k < 3; k++) begin
      set_window(k + 1);
      send_good(0, -1, 0);
    end
    flush();

    // Write landing on the same cycle its address is read: old value used, new next batch
    write_coef(0, 1);
    set_window(1);
    send_good(0, 2, -5);
    send_good(0, -1, 0);
    send_good(2, -1, 0);
    flush();

    // Extremes
    for (int i = 0; i < BS; i++) write_coef(i, -128);
    for (int i = 0; i < BS; i++) batch_d[i] = -128;
    for (int k = 0; k < 3; k++) send_good(2, -1, 0);
    flush();
    check("no_error_yet", error, 0);

    // Early eop on the 3rd beat, then a clean batch
    for (int i = 0; i < BS; i++) write_coef(i, i + 1);
    send_short(3);
    check("early_eop_error", error, 1);
    set_window(2);
    send_good(0, -1, 0);
    flush();

    // Mid-batch sop restarts; overlong batch discards; stray beat in idle
    beat(1'b1, 1'b0, 7);
    beat(1'b0, 1'b0, 9);
    set_window(3);
    send_good(0, -1, 0);
    send_long();
    set_window(4);
    send_good(2, -1, 0);
    beat(1'b0, 1'b1, 55);
    set_window(5);
    send_good(0, -1, 0);
    flush();

    // Randomized batches with occasional framing faults
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0)
        write_coef($urandom_range(0, BS - 1), $urandom_range(0, 255) - 128);
      for (int i = 0; i < BS; i++) batch_d[i] = $urandom_range(0, 255) - 128;
      mode = $urandom_range(0, 7);
      if (mode == 0) send_short($urandom_range(1, BS - 1));
      else if (mode == 1) send_long();
      else send_good($urandom_range(0, 2), -1, 0);
      gaps(2);
    end
    flush();
    check("sticky_error", error, 1);

    // Reset after beat 2 of a batch
    for (int i = 0; i < BS; i++) write_coef(i, i + 1);
    beat(1'b1, 1'b0, 1);
    beat(1'b0, 1'b0, 2);
    reset = 1'b1;
    tick();
    check("midreset_valid", source_valid, 0);
    check("midreset_sop", source_sop, 0);
    check("midreset_eop", source_eop, 0);
    check("midreset_data", source_data, 0);
    check("midreset_error", error, 0);
    reset = 1'b0;
    res_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      set_window(k + 1);
      send_good(0, -1, 0);
    end
    flush();
    check("post_reset_error", error, 0);
    check("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
